// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI mode-0 slave transaction controller.
package spi_pkg;

    localparam int SPI_ADDR_W = 7;
    localparam int SPI_DATA_W = 8;

    // R/W bit value (last command bit) that selects a read.
    localparam logic RW_READ = 1'b1;

    localparam logic [2:0] LAST_BIT = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_CMD,
        ST_READ_LOAD,
        ST_READ_SHIFT,
        ST_WRITE_SHIFT,
        ST_WRITE_COMMIT,
        ST_DONE
    } spi_state_t;

endpackage

// File: rtl/spi_shiftreg.sv
// Byte shift register: parallel load, MSB-first serial shift, parallel and serial out.
module spi_shiftreg
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              shift_en,
    input  logic              serial_in,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] par_out,
    output logic              serial_out
);

    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] sr_d;

    // Load wins over shift; the controller never asserts both.
    always_comb begin
        sr_d = sr_q;
        if (load_en) begin
            sr_d = load_data;
        end else if (shift_en) begin
            sr_d = {sr_q[DATA_W-2:0], serial_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign par_out    = sr_q;
    assign serial_out = sr_q[DATA_W-1];

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI mode-0 slave: decodes a command byte, then reads a memory byte out on MISO
// or shifts a byte in and commits it with a single-cycle write strobe.
module spi_slave_fsm
    import spi_pkg::*;
#(
    parameter int ADDR_W = SPI_ADDR_W,
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_cond,
    input  logic              mosi_cond,
    input  logic              sclk_posedge,
    input  logic              sclk_negedge,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              miso,
    output logic              miso_oe
);

    spi_state_t        state_q, state_d;
    logic [2:0]        count_q, count_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic              miso_q, miso_d;
    logic              miso_oe_q, miso_oe_d;

    logic              sr_load, sr_shift, sr_in, sr_msb;
    logic [DATA_W-1:0] sr_par;
    logic              last_edge;

    spi_shiftreg #(.DATA_W(DATA_W)) u_shiftreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en    (sr_load),
        .shift_en   (sr_shift),
        .serial_in  (sr_in),
        .load_data  (mem_rdata),
        .par_out    (sr_par),
        .serial_out (sr_msb)
    );

    assign last_edge = sclk_posedge && (count_q == LAST_BIT);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        mem_addr_d = mem_addr_q;
        mem_we_d   = 1'b0;
        miso_d     = miso_q;
        miso_oe_d  = miso_oe_q;
        sr_load    = 1'b0;
        sr_shift   = 1'b0;
        sr_in      = mosi_cond;

        // A deasserted chip select overrides everything, so a write whose last
        // bit coincides with CS release is never committed.
        if (cs_cond) begin
            state_d   = ST_IDLE;
            miso_oe_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_GET_CMD;
                    count_d = '0;
                end
                ST_GET_CMD: begin
                    if (sclk_posedge) begin
                        sr_shift = 1'b1;
                        count_d  = count_q + 3'd1;
                        if (last_edge) begin
                            mem_addr_d = sr_par[ADDR_W-1:0];
                            count_d    = '0;
                            state_d    = (mosi_cond == RW_READ) ? ST_READ_LOAD : ST_WRITE_SHIFT;
                        end
                    end
                end
                ST_READ_LOAD: begin
                    sr_load   = 1'b1;
                    miso_oe_d = 1'b1;
                    state_d   = ST_READ_SHIFT;
                end
                ST_READ_SHIFT: begin
                    if (sclk_posedge) begin
                        count_d = count_q + 3'd1;
                        if (last_edge) begin
                            count_d = '0;
                            state_d = ST_DONE;
                        end
                    end else if (sclk_negedge) begin
                        miso_d   = sr_msb;
                        sr_shift = 1'b1;
                        sr_in    = 1'b0;
                    end
                end
                ST_WRITE_SHIFT: begin
                    if (sclk_posedge) begin
                        sr_shift = 1'b1;
                        count_d  = count_q + 3'd1;
                        if (last_edge) begin
                            count_d  = '0;
                            mem_we_d = 1'b1;
                            state_d  = ST_WRITE_COMMIT;
                        end
                    end
                end
                ST_WRITE_COMMIT: begin
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            mem_addr_q <= mem_addr_d;
            mem_we_q   <= mem_we_d;
            miso_q     <= miso_d;
            miso_oe_q  <= miso_oe_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = sr_par;
    assign mem_we    = mem_we_q;
    assign miso      = miso_q;
    assign miso_oe   = miso_oe_q;

endmodule
